led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Sequencer for the board's 8-LED bank. It drives the LEDs in one of four selectable patterns: rotate-left ripple, rotate-right ripple, bounce, and blink. It has a step rate selectable in four levels and a pause switch. Push-button and switch inputs are synchronised and edge-detected inside the block, so it connects directly to FPGA pins between the board I/O and the LED outputs.

Parameters:
BASE_TICKS, 12500000, clk cycles per step at speed level 0 (0.25 s at 50 MHz); benches use 4
CNT_W, 32, tick counter width; must hold BASE_TICKS<<3

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
btn_mode  input  1  async push-button; each rising edge advances the pattern mode
btn_speed  input  1  async push-button; each rising edge advances the speed level
sw_pause  input  1  async level switch; 1 = freeze pattern and tick counter
led  output  8  LED drive, bit 0 = led0
mode  output  2  current mode (0 RIPPLE_L, 1 RIPPLE_R, 2 BOUNCE, 3 BLINK)
step  output  1  one-cycle pulse in the cycle the pattern advances

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - led=8'h01, mode=0, speed=0, cnt=0, bounce dir=LEFT, step=0.
  - All synchroniser and edge flops to 0.
- Input conditioning:
  - Each input passes through a 2-flop synchroniser.
  - Each button also has a third flop for rising-edge detect, producing a one-cycle pulse (mode_p, speed_p).
  - A button edge therefore acts 3 clk after the pin edge. Holding a button produces exactly one pulse.
- Period: period = BASE_TICKS << speed, giving speeds 0..3 = 1x, 2x, 4x, 8x BASE_TICKS.
- Tick counter:
  - When the synced pause is 0: if cnt == period-1, cnt<=0 and step<=1; otherwise cnt<=cnt+1 and step<=0.
  - When the synced pause is 1: cnt and led hold, step=0.
- mode_p:
  - mode <= mode+1 (wraps 3→0).
  - led is reloaded with the new mode's seed.
  - cnt<=0, step=0 that cycle.
  - Bounce dir<=LEFT.
  - Applies even while paused.
- speed_p:
  - speed <= speed+1 (wraps 3→0).
  - cnt<=0, step=0 that cycle.
  - led is unchanged.
  - Applies even while paused.
- Simultaneous mode_p and speed_p: both take effect in the same cycle.
- Priority within a cycle: reset > mode_p/speed_p (cnt clear and reload) > step advance > hold.
- Seeds: RIPPLE_L 8'h01, RIPPLE_R 8'h80, BOUNCE 8'h01, BLINK 8'h00.
- Pattern step, applied in the cycle step is asserted (led updates on the same edge that sets step):
  - RIPPLE_L: led <= {led[6:0], led[7]}.
  - RIPPLE_R: led <= {led[0], led[7:1]}.
  - BOUNCE is a two-state FSM (LEFT, RIGHT):
    - LEFT: if led[7], dir<=RIGHT and led<=led>>1; else led<=led<<1.
    - RIGHT: if led[0], dir<=LEFT and led<=led<<1; else led<=led>>1.
    - Sequence: 01,02,…,80,40,…,01,02… The end LEDs are lit for exactly one step each.
  - BLINK: led <= ~led (00↔FF).
- Invariant: in RIPPLE and BOUNCE modes, led is always one-hot.
- Reset mid-count or mid-bounce returns all state to the reset values on that edge; no step pulse is emitted.
- Latency: the first step after reset release occurs on the BASE_TICKS-th posedge with rst_n=1.

Test Plan:
1. BASE_TICKS=4, reset then run 32 cycles → step every 4th cycle; led 01→02→04→…→80→01; mode=0.
2. One btn_mode press → mode=1 and led=80 within 3 clk, cnt cleared; next steps give 40,20,…,01,80.
3. Press btn_mode twice (BOUNCE) and run 15 steps → led 01,02,…,80,40,…,01,02; each end value lasts exactly one step.
4. btn_speed pressed twice → speed=2, period 16; step pulses exactly 16 cycles apart; a 4th press wraps back to period 4.
5. BLINK mode (mode=3) with sw_pause=1 for 40 cycles → led frozen, step=0. Release pause → led resumes 00→FF toggling; cnt resumes from its held value, not 0.
6. btn_mode and btn_speed rising edges in the same cycle → mode+1 and speed+1 together, led=new seed. Assert rst_n=0 mid-count → led=01, mode=0, speed=0 next edge.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Pattern sequencer for an 8-LED bank: ripple left/right, bounce and blink.
// Buttons and switch are synchronised and edge-detected internally.
module led_pattern_ctrl #(
  parameter int unsigned BASE_TICKS = 12500000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_speed,
  input  logic       sw_pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       step
);

  localparam logic [1:0] MODE_RIPPLE_L = 2'd0;
  localparam logic [1:0] MODE_RIPPLE_R = 2'd1;
  localparam logic [1:0] MODE_BOUNCE   = 2'd2;
  localparam logic [1:0] MODE_BLINK    = 2'd3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  logic [2:0]       mode_sync;
  logic [2:0]       speed_sync;
  logic [1:0]       pause_sync;
  logic             mode_p;
  logic             speed_p;
  logic             pause_s;
  logic [1:0]       speed;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_c;
  logic [1:0]       next_mode_c;
  logic [7:0]       next_led_c;
  dir_t             dir;
  dir_t             next_dir_c;

  function automatic logic [7:0] seed(input logic [1:0] m);
    case (m)
      MODE_RIPPLE_L: seed = 8'h01;
      MODE_RIPPLE_R: seed = 8'h80;
      MODE_BOUNCE:   seed = 8'h01;
      default:       seed = 8'h00;
    endcase
  endfunction

  // Third flop of each button chain turns a held press into a single pulse.
  assign mode_p      = mode_sync[1] & ~mode_sync[2];
  assign speed_p     = speed_sync[1] & ~speed_sync[2];
  assign pause_s     = pause_sync[1];
  assign period_c    = CNT_W'(BASE_TICKS) << speed;
  assign next_mode_c = mode + 2'd1;

  // Pattern advance for the current mode, consumed only on a step.
  always_comb begin
    next_led_c = led;
    next_dir_c = dir;
    case (mode)
      MODE_RIPPLE_L: next_led_c = {led[6:0], led[7]};
      MODE_RIPPLE_R: next_led_c = {led[0], led[7:1]};
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          if (led[7]) begin
            next_dir_c = DIR_RIGHT;
            next_led_c = led >> 1;
          end else begin
            next_led_c = led << 1;
          end
        end else begin
          if (led[0]) begin
            next_dir_c = DIR_LEFT;
            next_led_c = led << 1;
          end else begin
            next_led_c = led >> 1;
          end
        end
      end
      default: next_led_c = ~led;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_sync  <= '0;
      speed_sync <= '0;
      pause_sync <= '0;
      led        <= 8'h01;
      mode       <= MODE_RIPPLE_L;
      speed      <= '0;
      cnt        <= '0;
      dir        <= DIR_LEFT;
      step       <= 1'b0;
    end else begin
      mode_sync  <= {mode_sync[1:0], btn_mode};
      speed_sync <= {speed_sync[1:0], btn_speed};
      pause_sync <= {pause_sync[0], sw_pause};
      step       <= 1'b0;
      // Button pulses win over counting and act even while paused.
      if (mode_p || speed_p) begin
        cnt <= '0;
        if (mode_p) begin
          mode <= next_mode_c;
          led  <= seed(next_mode_c);
          dir  <= DIR_LEFT;
        end
        if (speed_p) begin
          speed <= speed + 2'd1;
        end
      end else if (!pause_s) begin
        if (cnt == period_c - CNT_W'(1)) begin
          cnt  <= '0;
          step <= 1'b1;
          led  <= next_led_c;
          dir  <= next_dir_c;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with BASE_TICKS=4.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_speed;
  logic       sw_pause;
  logic [7:0] led;
  logic [1:0] mode;
  logic       step;

  int n_checks = 0;
  int n_pass   = 0;

  led_pattern_ctrl #(
    .BASE_TICKS(4),
    .CNT_W     (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_speed(btn_speed),
    .sw_pause (sw_pause),
    .led      (led),
    .mode     (mode),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic m, input logic s);
    btn_mode  = m;
    btn_speed = s;
    repeat (3) tick();
  endtask

  task automatic release_btns();
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Cycles until the next step pulse, bounded so a dead DUT cannot hang the run.
  task automatic wait_step(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!step && cycles < 200);
    check({tag, " step seen"}, 32'(step), 32'd1);
  endtask

  logic [7:0] bexp [0:14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int         cyc;
    logic [7:0] el;
    rst_n     = 1'b0;
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
    sw_pause  = 1'b0;
    repeat (3) tick();
    check("reset led", 32'(led), 32'h01);
    check("reset mode", 32'(mode), 32'd0);
    check("reset step", 32'(step), 32'd0);
    rst_n = 1'b1;

    // Ripple left at period 4; first step on the 4th posedge.
    el = 8'h01;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (i % 4 == 0) el = {el[6:0], el[7]};
      check($sformatf("rl step c%0d", i), 32'(step), 32'((i % 4) == 0));
      check($sformatf("rl led c%0d", i), 32'(led), 32'(el));
    end
    check("rl mode", 32'(mode), 32'd0);

    // One mode press: ripple right from 80.
    press(1'b1, 1'b0);
    check("rr mode", 32'(mode), 32'd1);
    check("rr seed", 32'(led), 32'h80);
    check("rr seed step", 32'(step), 32'd0);
    release_btns();
    el = 8'h80;
    for (int k = 0; k < 8; k++) begin
      wait_step("rr", cyc);
      el = {el[0], el[7:1]};
      check($sformatf("rr cycles %0d", k), 32'(cyc), (k == 0) ? 32'd1 : 32'd4);
      check($sformatf("rr led %0d", k), 32'(led), 32'(el));
    end

    // Two presses from reset reach bounce.
    do_reset();
    press(1'b1, 1'b0);
    release_btns();
    press(1'b1, 1'b0);
    check("bn mode", 32'(mode), 32'd2);
    check("bn seed", 32'(led), 32'h01);
    release_btns();
    for (int k = 0; k < 15; k++) begin
      wait_step("bn", cyc);
      check($sformatf("bn cycles %0d", k), 32'(cyc), (k == 0) ? 32'd1 : 32'd4);
      check($sformatf("bn led %0d", k), 32'(led), 32'(bexp[k]));
    end

    // Speed presses: period 16, then 32, then wrap to 4.
    press(1'b0, 1'b1);
    release_btns();
    press(1'b0, 1'b1);
    release_btns();
    wait_step("spd2a", cyc);
    check("spd2 first", 32'(cyc), 32'd13);
    wait_step("spd2b", cyc);
    check("spd2 period", 32'(cyc), 32'd16);
    press(1'b0, 1'b1);
    release_btns();
    wait_step("spd3a", cyc);
    check("spd3 first", 32'(cyc), 32'd29);
    wait_step("spd3b", cyc);
    check("spd3 period", 32'(cyc), 32'd32);
    press(1'b0, 1'b1);
    release_btns();
    wait_step("spd0a", cyc);
    check("spd0 first", 32'(cyc), 32'd1);
    wait_step("spd0b", cyc);
    check("spd0 period", 32'(cyc), 32'd4);
    check("spd mode kept", 32'(mode), 32'd2);

    // Blink with pause; counter resumes from its held value.
    press(1'b1, 1'b0);
    check("bl mode", 32'(mode), 32'd3);
    check("bl seed", 32'(led), 32'h00);
    release_btns();
    wait_step("bl0", cyc);
    check("bl first led", 32'(led), 32'hFF);
    sw_pause = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("pause step c%0d", i), 32'(step), 32'd0);
    end
    check("pause led", 32'(led), 32'hFF);
    sw_pause = 1'b0;
    wait_step("resume a", cyc);
    check("resume cycles", 32'(cyc), 32'd4);
    check("resume led a", 32'(led), 32'h00);
    wait_step("resume b", cyc);
    check("resume period", 32'(cyc), 32'd4);
    check("resume led b", 32'(led), 32'hFF);

    // Simultaneous presses, then reset on the would-be step edge.
    press(1'b1, 1'b1);
    check("both mode", 32'(mode), 32'd0);
    check("both seed", 32'(led), 32'h01);
    check("both step", 32'(step), 32'd0);
    release_btns();
    wait_step("both", cyc);
    check("both speed1", 32'(cyc), 32'd5);
    check("both led", 32'(led), 32'h02);
    repeat (7) tick();
    check("pre-reset step", 32'(step), 32'd0);
    rst_n = 1'b0;
    tick();
    check("midrst led", 32'(led), 32'h01);
    check("midrst mode", 32'(mode), 32'd0);
    check("midrst step", 32'(step), 32'd0);
    rst_n = 1'b1;
    wait_step("post rst", cyc);
    check("post rst latency", 32'(cyc), 32'd4);
    check("post rst led", 32'(led), 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
